// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: data width, opcode encodings and
// comparison result codes.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FUN_W  = 4;

  localparam logic [FUN_W-1:0] FUN_ADD  = 4'b0000;
  localparam logic [FUN_W-1:0] FUN_SUB  = 4'b0001;
  localparam logic [FUN_W-1:0] FUN_MUL  = 4'b0010;
  localparam logic [FUN_W-1:0] FUN_DIV  = 4'b0011;
  localparam logic [FUN_W-1:0] FUN_AND  = 4'b0100;
  localparam logic [FUN_W-1:0] FUN_OR   = 4'b0101;
  localparam logic [FUN_W-1:0] FUN_NAND = 4'b0110;
  localparam logic [FUN_W-1:0] FUN_NOR  = 4'b0111;
  localparam logic [FUN_W-1:0] FUN_XOR  = 4'b1000;
  localparam logic [FUN_W-1:0] FUN_XNOR = 4'b1001;
  localparam logic [FUN_W-1:0] FUN_CEQ  = 4'b1010;
  localparam logic [FUN_W-1:0] FUN_CGT  = 4'b1011;
  localparam logic [FUN_W-1:0] FUN_CLT  = 4'b1100;
  localparam logic [FUN_W-1:0] FUN_SHR  = 4'b1101;
  localparam logic [FUN_W-1:0] FUN_SHL  = 4'b1110;
  localparam logic [FUN_W-1:0] FUN_NOP  = 4'b1111;

  localparam logic [DATA_W-1:0] CMP_EQ = 16'd1;
  localparam logic [DATA_W-1:0] CMP_GT = 16'd2;
  localparam logic [DATA_W-1:0] CMP_LT = 16'd3;

  localparam logic [DATA_W-1:0] DIV_BY_ZERO = 16'hFFFF;

endpackage

// File: rtl/alu_flag_decoder.sv
// Combinational decode of the operation select into the four class flags;
// at most one flag is high and none for the no-op encoding.
module alu_flag_decoder
  import alu_pkg::*;
(
  input  logic [FUN_W-1:0] ALU_FUN,
  output logic             Arith_flag,
  output logic             Logic_flag,
  output logic             CMP_flag,
  output logic             Shift_flag
);

  always_comb begin
    Arith_flag = 1'b0;
    Logic_flag = 1'b0;
    CMP_flag   = 1'b0;
    Shift_flag = 1'b0;
    case (ALU_FUN)
      FUN_ADD, FUN_SUB, FUN_MUL, FUN_DIV:                     Arith_flag = 1'b1;
      FUN_AND, FUN_OR, FUN_NAND, FUN_NOR, FUN_XOR, FUN_XNOR:  Logic_flag = 1'b1;
      FUN_CEQ, FUN_CGT, FUN_CLT:                              CMP_flag   = 1'b1;
      FUN_SHR, FUN_SHL:                                       Shift_flag = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_module.sv
// 16-bit ALU: one combinational result mux feeding a single output register,
// plus combinational class flags decoded from ALU_FUN.
module alu_module
  import alu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [FUN_W-1:0]  ALU_FUN,
  output logic [DATA_W-1:0] ALU_OUT,
  output logic              Arith_flag,
  output logic              Logic_flag,
  output logic              CMP_flag,
  output logic              Shift_flag
);

  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] r_alu_out;

  // Arithmetic is evaluated in the 16-bit result context, so carry, borrow
  // and the upper product bits wrap away naturally.
  always_comb begin
    w_result = '0;
    case (ALU_FUN)
      FUN_ADD:  w_result = A + B;
      FUN_SUB:  w_result = A - B;
      FUN_MUL:  w_result = A * B;
      FUN_DIV:  w_result = (B == '0) ? DIV_BY_ZERO : A / B;
      FUN_AND:  w_result = A & B;
      FUN_OR:   w_result = A | B;
      FUN_NAND: w_result = ~(A & B);
      FUN_NOR:  w_result = ~(A | B);
      FUN_XOR:  w_result = A ^ B;
      FUN_XNOR: w_result = ~(A ^ B);
      FUN_CEQ:  w_result = (A == B) ? CMP_EQ : '0;
      FUN_CGT:  w_result = (A > B)  ? CMP_GT : '0;
      FUN_CLT:  w_result = (A < B)  ? CMP_LT : '0;
      FUN_SHR:  w_result = A >> 1;
      FUN_SHL:  w_result = A << 1;
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_alu_out <= '0;
    else      r_alu_out <= w_result;
  end

  assign ALU_OUT = r_alu_out;

  alu_flag_decoder u_flag_decoder (
    .ALU_FUN    (ALU_FUN),
    .Arith_flag (Arith_flag),
    .Logic_flag (Logic_flag),
    .CMP_flag   (CMP_flag),
    .Shift_flag (Shift_flag)
  );

endmodule

// File: tb/tb_alu_module.sv
// Directed-vector bench for alu_module with hand-computed expectations.
module tb_alu_module;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        Arith_flag;
  logic        Logic_flag;
  logic        CMP_flag;
  logic        Shift_flag;

  int unsigned n_total;
  int unsigned n_bad;

  alu_module dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .Arith_flag (Arith_flag),
    .Logic_flag (Logic_flag),
    .CMP_flag   (CMP_flag),
    .Shift_flag (Shift_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] flags_now();
    return {12'd0, Arith_flag, Logic_flag, CMP_flag, Shift_flag};
  endfunction

  // exp_flags order: {Arith, Logic, CMP, Shift}
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] fun, input logic [15:0] exp,
                       input logic [3:0] exp_flags);
    @(negedge CLK);
    A = a; B = b; ALU_FUN = fun;
    #1;
    check({tag, "_flags"}, flags_now(), {12'd0, exp_flags});
    @(posedge CLK);
    #1;
    check(tag, ALU_OUT, exp);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    RST = 1'b0; A = '0; B = '0; ALU_FUN = 4'b1111;
    #2;
    check("reset_out", ALU_OUT, 16'h0000);
    check("reset_flags_nop", flags_now(), 16'h0000);
    ALU_FUN = 4'b0101;
    #1;
    check("reset_flags_logic", flags_now(), 16'h0004);
    @(negedge CLK);
    RST = 1'b1;

    apply("add",      16'd10,    16'd20, 4'b0000, 16'd30,    4'b1000);
    apply("sub",      16'd20,    16'd10, 4'b0001, 16'd10,    4'b1000);
    apply("sub_wrap", 16'd0,     16'd1,  4'b0001, 16'hFFFF,  4'b1000);
    apply("add_wrap", 16'hFFFF,  16'd1,  4'b0000, 16'h0000,  4'b1000);
    apply("mul",      16'd20,    16'd10, 4'b0010, 16'd200,   4'b1000);
    apply("mul_wrap", 16'd300,   16'd300,4'b0010, 16'd24464, 4'b1000);
    apply("div",      16'd20,    16'd10, 4'b0011, 16'd2,     4'b1000);
    apply("div_trunc",16'd7,     16'd2,  4'b0011, 16'd3,     4'b1000);
    apply("div_zero", 16'd7,     16'd0,  4'b0011, 16'hFFFF,  4'b1000);
    apply("and",      16'd20,    16'd10, 4'b0100, 16'd0,     4'b0100);
    apply("or",       16'd20,    16'd10, 4'b0101, 16'd30,    4'b0100);
    apply("nand",     16'd20,    16'd10, 4'b0110, 16'd65535, 4'b0100);
    apply("nor",      16'd20,    16'd10, 4'b0111, 16'd65505, 4'b0100);
    apply("xor",      16'd20,    16'd10, 4'b1000, 16'd30,    4'b0100);
    apply("xnor",     16'd20,    16'd10, 4'b1001, 16'd65505, 4'b0100);
    apply("ceq_ne",   16'd20,    16'd10, 4'b1010, 16'd0,     4'b0010);
    apply("cgt",      16'd20,    16'd10, 4'b1011, 16'd2,     4'b0010);
    apply("clt_no",   16'd20,    16'd10, 4'b1100, 16'd0,     4'b0010);
    apply("ceq",      16'd5,     16'd5,  4'b1010, 16'd1,     4'b0010);
    apply("cgt_eq",   16'd5,     16'd5,  4'b1011, 16'd0,     4'b0010);
    apply("clt",      16'd3,     16'd9,  4'b1100, 16'd3,     4'b0010);
    apply("clt_big",  16'h0001,  16'h8000,4'b1100,16'd3,     4'b0010);
    apply("shr",      16'd20,    16'd99, 4'b1101, 16'd10,    4'b0001);
    apply("shl",      16'd20,    16'd99, 4'b1110, 16'd40,    4'b0001);
    apply("shl_msb",  16'h8001,  16'd0,  4'b1110, 16'h0002,  4'b0001);
    apply("shr_msb",  16'h8001,  16'hFFFF,4'b1101,16'h4000,  4'b0001);
    apply("nop",      16'd20,    16'd10, 4'b1111, 16'd0,     4'b0000);

    // inputs change between edges, async reset mid-cycle, then recovery
    apply("pre_rst",  16'd10,    16'd20, 4'b0000, 16'd30,    4'b1000);
    @(negedge CLK);
    A = 16'd1; B = 16'd2; ALU_FUN = 4'b0010;
    #1;
    check("hold_between_edges", ALU_OUT, 16'd30);
    RST = 1'b0;
    #1;
    check("async_clear", ALU_OUT, 16'h0000);
    check("flags_in_reset", flags_now(), 16'h0008);
    @(posedge CLK);
    #1;
    check("discard_pending", ALU_OUT, 16'h0000);
    ALU_FUN = 4'b1111;
    #1;
    check("nop_flags_in_reset", flags_now(), 16'h0000);
    @(negedge CLK);
    A = 16'd5; B = 16'd6; ALU_FUN = 4'b0000;
    RST = 1'b1;
    #1;
    check("still_zero_after_release", ALU_OUT, 16'h0000);
    @(posedge CLK);
    #1;
    check("first_after_reset", ALU_OUT, 16'd11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_module.md
ALU_MODULE -- requirements
Module: alu_module

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have the port CLK: input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have the port RST: input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have the port A: input, 16 bits, unsigned operand A.
REQ-005 The block SHALL have the port B: input, 16 bits, unsigned operand B.
REQ-006 The block SHALL have the port ALU_FUN: input, 4 bits, operation select.
REQ-007 The block SHALL have the port ALU_OUT: output, 16 bits, registered result.
REQ-008 The block SHALL have the port Arith_flag: output, 1 bit, high when ALU_FUN is 0000-0011.
REQ-009 The block SHALL have the port Logic_flag: output, 1 bit, high when ALU_FUN is 0100-1001.
REQ-010 The block SHALL have the port CMP_flag: output, 1 bit, high when ALU_FUN is 1010-1100.
REQ-011 The block SHALL have the port Shift_flag: output, 1 bit, high when ALU_FUN is 1101-1110.

Function
REQ-012 ALU_OUT SHALL be registered, with the result of the current A, B and ALU_FUN loaded on every rising CLK edge (1-cycle latency, no enable, no handshake).
REQ-013 The flags SHALL be combinational decodes of ALU_FUN, at most one high at a time, and all low for 1111.
REQ-014 The operation encoding SHALL be:
- 0000: A+B
- 0001: A-B
- 0010: A*B
- 0011: A/B
- 0100: A&B
- 0101: A|B
- 0110: ~(A&B)
- 0111: ~(A|B)
- 1000: A^B
- 1001: ~(A^B)
REQ-015 Arithmetic results SHALL be truncated to 16 bits modulo 2^16, covering add carry-out, subtract borrow (wraps) and the product's low 16 bits.
REQ-016 Division SHALL be unsigned integer (quotient truncated toward zero), and B=0 SHALL yield 16'hFFFF.
REQ-017 For 1010, ALU_OUT SHALL be 1 if A==B, else 0.
REQ-018 For 1011, ALU_OUT SHALL be 2 if A>B (unsigned), else 0.
REQ-019 For 1100, ALU_OUT SHALL be 3 if A<B (unsigned), else 0.
REQ-020 For 1101, ALU_OUT SHALL be A>>1 (logical, MSB filled with 0); B SHALL be ignored.
REQ-021 For 1110, ALU_OUT SHALL be A<<1 (bit 15 discarded, LSB filled with 0); B SHALL be ignored.
REQ-022 For 1111, ALU_OUT SHALL be 0.
REQ-023 Input changes between edges SHALL NOT affect ALU_OUT until the next rising edge.

Reset
REQ-024 RST low SHALL immediately clear ALU_OUT to 16'h0000, independent of CLK.
REQ-025 Flags SHALL remain pure ALU_FUN decodes during reset.
REQ-026 On RST deassertion, the first rising edge SHALL load a normal result.
REQ-027 Reset asserted mid-operation SHALL discard the pending result.

Structure
REQ-028 A shared package alu_pkg SHALL hold the 16 opcode localparams, the data width (16) and the comparison result codes (1/2/3).
REQ-029 The datapath SHALL be a single combinational case statement feeding one output register.
REQ-030 An optional sub-module alu_flag_decoder MAY hold the four-flag decode; no other hierarchy SHALL be used.

Verification
REQ-031 Add/sub: A=10,B=20,FUN=0000 -> ALU_OUT=30 one edge later, Arith_flag=1; A=20,B=10,FUN=0001 -> 10; A=0,B=1,FUN=0001 -> 16'hFFFF.
REQ-032 Mul/div: A=20,B=10,FUN=0010 -> 200; FUN=0011 -> 2; A=7,B=0,FUN=0011 -> 16'hFFFF.
REQ-033 Logic ops with A=20,B=10 SHALL give:
- AND -> 0
- OR -> 30
- NAND -> 65535
- NOR -> 65505
- XOR -> 30
- XNOR -> 65505
- Logic_flag=1 for all six
REQ-034 Compare with A=20,B=10: FUN=1010 -> 0, FUN=1011 -> 2, FUN=1100 -> 0; with A=B=5: FUN=1010 -> 1; with A=3,B=9: FUN=1100 -> 3; CMP_flag=1.
REQ-035 Shift: A=20,FUN=1101 -> 10; FUN=1110 -> 40; A=16'h8001,FUN=1110 -> 16'h0002; Shift_flag=1.
REQ-036 Reset: RST low between edges with ALU_OUT=30 -> ALU_OUT=0 immediately; FUN=1111 -> ALU_OUT=0 with all flags 0.
